// File: rtl/tlc_input_cond.sv
// Input conditioning for the traffic light controller: synchronised, debounced
// and latched vehicle requests plus a time-of-day clock with peak-window flag.
module tlc_input_cond #(
    parameter int PRESCALE   = 60,
    parameter int DEB_CYCLES = 4,
    parameter int AM_START   = 420,
    parameter int AM_END     = 600,
    parameter int PM_START   = 1020,
    parameter int PM_END     = 1200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sensor1_raw,
    input  logic        sensor2_raw,
    input  logic        clr1,
    input  logic        clr2,
    input  logic        peak_force,
    input  logic        tod_set,
    input  logic [10:0] tod_val,
    output logic        sensor1,
    output logic        sensor2,
    output logic        peak,
    output logic [10:0] tod_min
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [10:0]   TOD_LAST  = 11'd1439;
    localparam logic [10:0]   AM_S      = 11'(AM_START);
    localparam logic [10:0]   AM_E      = 11'(AM_END);
    localparam logic [10:0]   PM_S      = 11'(PM_START);
    localparam logic [10:0]   PM_E      = 11'(PM_END);

    // Half-open window test [lo, hi) on a minute-of-day value.
    function automatic logic in_window(input logic [10:0] m,
                                       input logic [10:0] lo,
                                       input logic [10:0] hi);
        return (m >= lo) && (m < hi);
    endfunction

    logic [1:0] raw;
    logic [1:0] clr;
    logic [1:0] sensor;

    assign raw     = {sensor2_raw, sensor1_raw};
    assign clr     = {clr2, clr1};
    assign sensor1 = sensor[0];
    assign sensor2 = sensor[1];

    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic          s1;
        logic          s2;
        logic          deb;
        logic          req;
        logic [CW-1:0] cnt;
        logic          differ;
        logic          flip;

        // The toggle happens on the edge that would make the count reach DEB_CYCLES.
        assign differ = s2 ^ deb;
        assign flip   = differ && (cnt == DEB_LAST);

        always_ff @(posedge clk) begin
            if (!reset) begin
                s1  <= 1'b0;
                s2  <= 1'b0;
                deb <= 1'b0;
                cnt <= '0;
                req <= 1'b0;
            end else begin
                s1 <= raw[g];
                s2 <= s1;
                if (flip) begin
                    deb <= ~deb;
                    cnt <= '0;
                end else if (differ) begin
                    cnt <= cnt + CW'(1);
                end else begin
                    cnt <= '0;
                end
                // A fresh arrival outranks a coincident clear.
                if (flip && !deb)
                    req <= 1'b1;
                else if (clr[g])
                    req <= 1'b0;
            end
        end

        // A vehicle still on the loop keeps the request visible after a clear.
        assign sensor[g] = req | deb;
    end

    logic [PW-1:0] pcnt;
    logic          tick;
    logic          load;

    assign tick = (pcnt == PCNT_LAST);
    assign load = tod_set && (tod_val <= TOD_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pcnt    <= '0;
            tod_min <= '0;
            peak    <= 1'b0;
        end else begin
            if (load || tick)
                pcnt <= '0;
            else
                pcnt <= pcnt + PW'(1);

            if (load)
                tod_min <= tod_val;
            else if (tick)
                tod_min <= (tod_min == TOD_LAST) ? 11'd0 : tod_min + 11'd1;

            peak <= in_window(tod_min, AM_S, AM_E) ||
                    in_window(tod_min, PM_S, PM_E) ||
                    peak_force;
        end
    end

endmodule

// File: tb/tb_tlc_input_cond.sv
// Bench for tlc_input_cond: directed scenarios then random traffic, all
// checked every cycle against a window/elapsed-time reference model.
module tb_tlc_input_cond;
    localparam int PRESCALE = 60;
    localparam int DEB      = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        sensor1_raw, sensor2_raw;
    logic        clr1, clr2;
    logic        peak_force;
    logic        tod_set;
    logic [10:0] tod_val;
    logic        sensor1, sensor2, peak;
    logic [10:0] tod_min;

    always #5 clk = ~clk;

    tlc_input_cond #(
        .PRESCALE(PRESCALE), .DEB_CYCLES(DEB),
        .AM_START(420), .AM_END(600), .PM_START(1020), .PM_END(1200)
    ) dut (
        .clk(clk), .reset(reset),
        .sensor1_raw(sensor1_raw), .sensor2_raw(sensor2_raw),
        .clr1(clr1), .clr2(clr2), .peak_force(peak_force),
        .tod_set(tod_set), .tod_val(tod_val),
        .sensor1(sensor1), .sensor2(sensor2), .peak(peak), .tod_min(tod_min)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: edge index, raw history, last toggle edges,
    // and the time-of-day expressed as a base value plus elapsed edges.
    int k = -1;
    int rst_edge = -1;
    bit rawh0[$];
    bit rawh1[$];
    int lt[2];
    bit m_deb[2];
    bit m_req[2];
    int tod_base = 0;
    int base_edge = 0;
    int m_tod = 0;
    bit m_peak = 0;

    function automatic bit s2_before(input int c, input int i);
        int j;
        j = i - 2;
        if (j <= rst_edge) return 1'b0;
        return (c == 0) ? rawh0[j] : rawh1[j];
    endfunction

    function automatic bit peak_window(input int m);
        return (m >= 420 && m < 600) || (m >= 1020 && m < 1200);
    endfunction

    task automatic model_edge();
        int  floor_e;
        bit  tog;
        bit  rise;
        bit  clrv;
        k++;
        rawh0.push_back(sensor1_raw);
        rawh1.push_back(sensor2_raw);
        if (!reset) begin
            rst_edge  = k;
            for (int c = 0; c < 2; c++) begin
                m_deb[c] = 1'b0;
                m_req[c] = 1'b0;
                lt[c]    = k;
            end
            tod_base  = 0;
            base_edge = k;
            m_tod     = 0;
            m_peak    = 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                floor_e = (lt[c] > rst_edge) ? lt[c] : rst_edge;
                tog = (k - DEB + 1 > floor_e);
                for (int i = k - DEB + 1; i <= k; i++)
                    if (tog && s2_before(c, i) == m_deb[c]) tog = 1'b0;
                rise = tog && !m_deb[c];
                if (tog) begin
                    m_deb[c] = ~m_deb[c];
                    lt[c]    = k;
                end
                clrv = (c == 0) ? clr1 : clr2;
                if (rise) m_req[c] = 1'b1;
                else if (clrv) m_req[c] = 1'b0;
            end
            m_peak = peak_window(m_tod) || peak_force;
            if (tod_set && tod_val <= 11'd1439) begin
                tod_base  = int'(tod_val);
                base_edge = k;
            end
            m_tod = (tod_base + (k - base_edge) / PRESCALE) % 1440;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("sensor1", 32'(sensor1), 32'(m_req[0] | m_deb[0]));
        check("sensor2", 32'(sensor2), 32'(m_req[1] | m_deb[1]));
        check("peak",    32'(peak),    32'(m_peak));
        check("tod_min", 32'(tod_min), 32'(m_tod));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_tod(input int v);
        tod_set = 1'b1;
        tod_val = 11'(v);
        step();
        tod_set = 1'b0;
    endtask

    initial begin
        int pick;
        reset = 1'b0; sensor1_raw = 1'b0; sensor2_raw = 1'b0;
        clr1 = 1'b0; clr2 = 1'b0; peak_force = 1'b0;
        tod_set = 1'b0; tod_val = 11'd0;

        // Reset state
        run(3);
        check("rst_sensor1", 32'(sensor1), 32'd0);
        check("rst_peak", 32'(peak), 32'd0);
        check("rst_tod", 32'(tod_min), 32'd0);
        reset = 1'b1;
        run(2);

        // Debounce latency on sensor1
        sensor1_raw = 1'b1;
        run(5);
        check("lat_edge4_s1", 32'(sensor1), 32'd0);
        run(1);
        check("lat_edge5_s1", 32'(sensor1), 32'd1);
        check("lat_s2_quiet", 32'(sensor2), 32'd0);

        // Clear while vehicle still present
        clr1 = 1'b1; step(); clr1 = 1'b0;
        check("clr_while_high", 32'(sensor1), 32'd1);
        sensor1_raw = 1'b0;
        run(6);
        check("deb_fall_after_clr", 32'(sensor1), 32'd0);

        // Rise coincident with clear: set wins
        sensor1_raw = 1'b1;
        run(5);
        clr1 = 1'b1; step(); clr1 = 1'b0;
        check("rise_with_clr", 32'(sensor1), 32'd1);
        sensor1_raw = 1'b0;
        run(6);
        check("req_holds_after_leave", 32'(sensor1), 32'd1);
        clr1 = 1'b1; step(); clr1 = 1'b0;
        check("clr1_drops", 32'(sensor1), 32'd0);

        // Glitch rejection then accepted pulse on sensor2
        sensor2_raw = 1'b1; run(3); sensor2_raw = 1'b0; run(8);
        check("glitch3_s2", 32'(sensor2), 32'd0);
        sensor2_raw = 1'b1; run(6); sensor2_raw = 1'b0; run(8);
        check("pulse6_s2", 32'(sensor2), 32'd1);
        clr2 = 1'b1; step(); clr2 = 1'b0;
        check("clr2_drops", 32'(sensor2), 32'd0);

        // Minute wrap 1439 -> 0
        load_tod(1439);
        check("load_1439", 32'(tod_min), 32'd1439);
        run(59);
        check("hold_1439", 32'(tod_min), 32'd1439);
        run(1);
        check("wrap_to_0", 32'(tod_min), 32'd0);
        load_tod(2000);
        check("ignore_2000", 32'(tod_min), 32'd0);

        // AM window edges
        load_tod(419);
        run(1);
        check("peak_419", 32'(peak), 32'd0);
        run(58);
        run(1);
        check("tod_420", 32'(tod_min), 32'd420);
        check("peak_lag_420", 32'(peak), 32'd0);
        run(1);
        check("peak_420", 32'(peak), 32'd1);
        load_tod(599);
        run(60);
        check("tod_600", 32'(tod_min), 32'd600);
        run(1);
        check("peak_600", 32'(peak), 32'd0);

        // Manual override
        load_tod(300);
        peak_force = 1'b1; step();
        check("force_on", 32'(peak), 32'd1);
        peak_force = 1'b0; step();
        check("force_off", 32'(peak), 32'd0);

        // Reset mid-debounce
        load_tod(500);
        sensor1_raw = 1'b1;
        run(4);
        reset = 1'b0; step();
        check("midrst_s1", 32'(sensor1), 32'd0);
        check("midrst_tod", 32'(tod_min), 32'd0);
        check("midrst_peak", 32'(peak), 32'd0);
        reset = 1'b1;
        run(5);
        check("restart_edge4", 32'(sensor1), 32'd0);
        run(1);
        check("restart_edge5", 32'(sensor1), 32'd1);
        sensor1_raw = 1'b0;
        run(8);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) sensor1_raw = ~sensor1_raw;
            if ($urandom_range(0, 3) == 0) sensor2_raw = ~sensor2_raw;
            clr1 = ($urandom_range(0, 7) == 0);
            clr2 = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) peak_force = ~peak_force;
            tod_set = ($urandom_range(0, 99) == 0);
            pick = int'($urandom_range(0, 6));
            case (pick)
                0: tod_val = 11'd419;
                1: tod_val = 11'd599;
                2: tod_val = 11'd1019;
                3: tod_val = 11'd1199;
                4: tod_val = 11'd1439;
                default: tod_val = 11'($urandom_range(0, 2047));
            endcase
            reset = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
